system_key_pio: RTL

- Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO. Lets the Nios II read push-buttons/switches and take interrupts on them.
- Synchronises and debounces an external input bus, exposes the debounced level, latches edges into an edge-capture register and raises a maskable level interrupt.
- Sits on the system interconnect beside the LED PIO; its irq is wired to the CPU interrupt controller.

---
 rtl/system_key_pio.sv | 139 +++++++++++++
 1 files changed

// File: rtl/system_key_pio.sv
// ---------------------------------------------------------------------------
// system_key_pio
//   Avalon-MM slave input PIO for push-buttons / switches. The external bus is
//   passed through a two-flop synchroniser, debounced per bit, and the accepted
//   level is exposed for reading. Selected edges of the debounced level are
//   latched into a write-1-to-clear edge-capture register, which together with
//   an interrupt mask drives a level interrupt towards the CPU.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word address (0 DATA, 1 reserved, 2 IRQ_MASK,
//               3 EDGE_CAPTURE)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, valid the cycle after address
//   irq         active-high level interrupt
// ---------------------------------------------------------------------------
module system_key_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_deb_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge_sel;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_wr;
  logic             w_unused;

  // Upper writedata bits have no destination when WIDTH < 32.
  assign w_unused = &{1'b0, writedata};

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples that differ from the current level; any
  // sample matching the current level restarts the count.
  always_comb begin
    w_deb_next = r_deb;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_deb[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_deb_next[i] = r_sync2[i];
        w_cnt_next[i] = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;
  assign w_fall = ~r_deb & r_deb_d;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge_sel = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge_sel = w_fall;
    end else begin : g_any
      assign w_edge_sel = w_rise | w_fall;
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_deb;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= IN_RESET_VALUE;
      r_sync2    <= IN_RESET_VALUE;
      r_deb      <= IN_RESET_VALUE;
      r_deb_d    <= IN_RESET_VALUE;
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_deb      <= w_deb_next;
      r_deb_d    <= r_deb;
      r_readdata <= w_rd_mux;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      if (w_wr && (address == 2'd2)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // Set is applied after clear so an edge arriving with a clear survives.
      r_edge <= (r_edge & ~w_clr) | w_edge_sel;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule
